// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP controller: 16-state FSM, IR, IDCODE/BYPASS
// registers, user scan-chain selects and a falling-edge TDO register.
module jtag_tap_param #(
    parameter int          IR_LEN       = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
    parameter int          N_CHAINS     = 3,
    parameter int          CHAIN_BASE   = 8,
    parameter int          EXTEST_OP    = 0,
    parameter int          SAMPLE_OP    = 1,
    parameter int          IDCODE_OP    = 2
) (
    input  logic                tck_pad_i,
    input  logic                trst_pad_i,
    input  logic                tms_pad_i,
    input  logic                tdi_pad_i,
    output logic                tdo_pad_o,
    output logic                tdo_padoe_o,
    output logic                shift_dr_o,
    output logic                pause_dr_o,
    output logic                update_dr_o,
    output logic                capture_dr_o,
    output logic                extest_select_o,
    output logic                sample_preload_select_o,
    output logic [N_CHAINS-1:0] chain_select_o,
    input  logic                bs_chain_tdi_i,
    input  logic [N_CHAINS-1:0] chain_tdi_i
);

    localparam int CHAIN_LAST = CHAIN_BASE + N_CHAINS - 1;
    localparam int ALL_ONES   = (1 << IR_LEN) - 1;

    localparam logic [IR_LEN-1:0] EXTEST_CODE = IR_LEN'(EXTEST_OP);
    localparam logic [IR_LEN-1:0] SAMPLE_CODE = IR_LEN'(SAMPLE_OP);
    localparam logic [IR_LEN-1:0] IDCODE_CODE = IR_LEN'(IDCODE_OP);

    if (IR_LEN < 2 || N_CHAINS < 1 || IDCODE_VALUE[0] != 1'b1 || CHAIN_BASE < 0 ||
        CHAIN_LAST >= ALL_ONES ||
        (EXTEST_OP >= CHAIN_BASE && EXTEST_OP <= CHAIN_LAST) ||
        (SAMPLE_OP >= CHAIN_BASE && SAMPLE_OP <= CHAIN_LAST) ||
        (IDCODE_OP >= CHAIN_BASE && IDCODE_OP <= CHAIN_LAST)) begin : g_bad_params
        $error("jtag_tap_param: illegal opcode/parameter combination");
    end

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_t;

    tap_state_t        state, next_state;
    logic [IR_LEN-1:0] ir, ir_shift;
    logic [31:0]       idcode_shift;
    logic              bypass_reg;
    logic              idcode_sel, bs_sel, chain_hit, chain_tdo, tdo_mux, shifting;

    always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) state <= TEST_LOGIC_RESET;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TEST_LOGIC_RESET: next_state = tms_pad_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state = tms_pad_i ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        next_state = tms_pad_i ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       next_state = tms_pad_i ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         next_state = tms_pad_i ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         next_state = tms_pad_i ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         next_state = tms_pad_i ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         next_state = tms_pad_i ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        next_state = tms_pad_i ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        next_state = tms_pad_i ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next_state = tms_pad_i ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         next_state = tms_pad_i ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         next_state = tms_pad_i ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         next_state = tms_pad_i ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         next_state = tms_pad_i ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        next_state = tms_pad_i ? SELECT_DR : RUN_TEST_IDLE;
            default:          next_state = TEST_LOGIC_RESET;
        endcase
    end

    // IR is forced on entry to Test-Logic-Reset so the selects drop as soon as the FSM lands there.
    always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) begin
            ir       <= IDCODE_CODE;
            ir_shift <= '0;
        end else begin
            if (state == CAPTURE_IR)    ir_shift <= IR_LEN'(1);
            else if (state == SHIFT_IR) ir_shift <= {tdi_pad_i, ir_shift[IR_LEN-1:1]};
            if (next_state == TEST_LOGIC_RESET) ir <= IDCODE_CODE;
            else if (state == UPDATE_IR)        ir <= ir_shift;
        end
    end

    always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) begin
            idcode_shift <= '0;
            bypass_reg   <= 1'b0;
        end else begin
            if (state == CAPTURE_DR && idcode_sel)    idcode_shift <= IDCODE_VALUE;
            else if (state == SHIFT_DR && idcode_sel) idcode_shift <= {tdi_pad_i, idcode_shift[31:1]};
            if (state == CAPTURE_DR)    bypass_reg <= 1'b0;
            else if (state == SHIFT_DR) bypass_reg <= tdi_pad_i;
        end
    end

    always_comb begin
        chain_select_o = '0;
        for (int unsigned i = 0; i < N_CHAINS; i++)
            chain_select_o[i] = (ir == IR_LEN'(CHAIN_BASE + int'(i)));
    end

    assign idcode_sel              = (ir == IDCODE_CODE);
    assign extest_select_o         = (ir == EXTEST_CODE);
    assign sample_preload_select_o = (ir == SAMPLE_CODE);
    assign bs_sel                  = extest_select_o | sample_preload_select_o;
    assign chain_hit               = |chain_select_o;
    assign chain_tdo               = |(chain_select_o & chain_tdi_i);

    assign shift_dr_o   = (state == SHIFT_DR);
    assign pause_dr_o   = (state == PAUSE_DR);
    assign update_dr_o  = (state == UPDATE_DR);
    assign capture_dr_o = (state == CAPTURE_DR);
    assign shifting     = (state == SHIFT_DR) || (state == SHIFT_IR);

    always_comb begin
        tdo_mux = bypass_reg;
        if (state == SHIFT_IR) tdo_mux = ir_shift[0];
        else if (idcode_sel)   tdo_mux = idcode_shift[0];
        else if (bs_sel)       tdo_mux = bs_chain_tdi_i;
        else if (chain_hit)    tdo_mux = chain_tdo;
    end

    always_ff @(negedge tck_pad_i or negedge trst_pad_i) begin
        if (!trst_pad_i) begin
            tdo_pad_o   <= 1'b0;
            tdo_padoe_o <= 1'b0;
        end else begin
            tdo_pad_o   <= shifting ? tdo_mux : 1'b0;
            tdo_padoe_o <= shifting;
        end
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Self-checking bench for jtag_tap_param: directed TAP scenarios plus randomised
// opcode/data scans and a random TMS walk checked against a table-driven model.
module tb_jtag_tap_param;

    localparam logic [31:0] IDCODE = 32'h149511C3;

    logic       tck = 1'b0;
    logic       trst, tms, tdi, tdo, tdo_oe;
    logic       shift_dr, pause_dr, update_dr, capture_dr, extest_sel, sample_sel;
    logic [2:0] chain_sel, chain_tdi;
    logic       bs_tdi;
    int         total = 0;
    int         bad = 0;

    jtag_tap_param #(
        .IR_LEN(4), .IDCODE_VALUE(IDCODE), .N_CHAINS(3), .CHAIN_BASE(8),
        .EXTEST_OP(0), .SAMPLE_OP(1), .IDCODE_OP(2)
    ) dut (
        .tck_pad_i(tck), .trst_pad_i(trst), .tms_pad_i(tms), .tdi_pad_i(tdi),
        .tdo_pad_o(tdo), .tdo_padoe_o(tdo_oe),
        .shift_dr_o(shift_dr), .pause_dr_o(pause_dr), .update_dr_o(update_dr),
        .capture_dr_o(capture_dr), .extest_select_o(extest_sel),
        .sample_preload_select_o(sample_sel), .chain_select_o(chain_sel),
        .bs_chain_tdi_i(bs_tdi), .chain_tdi_i(chain_tdi)
    );

    always #10 tck = ~tck;

    // One TCK: inputs applied just after a falling edge, returns just after the next falling edge.
    task automatic clk(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck); #1;
        @(negedge tck); #1;
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            clk(i == n - 1, din[i]);
        end
    endtask

    task automatic load_ir(input logic [3:0] op, output logic [3:0] captured);
        logic [63:0] d;
        clk(1, 0); clk(1, 0); clk(0, 0); clk(0, 0);
        shift_bits(4, {60'd0, op}, d);
        clk(1, 0); clk(0, 0);
        captured = d[3:0];
    endtask

    task automatic read_idcode(output logic [31:0] v);
        logic [63:0] d;
        clk(1, 0); clk(0, 0); clk(0, 0);
        shift_bits(32, '0, d);
        clk(1, 0); clk(0, 0);
        v = d[31:0];
    endtask

    task automatic test_reset;
        trst = 1'b0; tms = 1'b1; tdi = 1'b0; bs_tdi = 1'b0; chain_tdi = '0;
        #15;
        total++;
        if ({tdo, tdo_oe, shift_dr, pause_dr, update_dr, capture_dr} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=000000",
                {tdo, tdo_oe, shift_dr, pause_dr, update_dr, capture_dr});
        end
        total++;
        if ({extest_sel, sample_sel, chain_sel} !== 5'b0) begin
            bad++; $display("FAIL reset_selects got=%b exp=00000", {extest_sel, sample_sel, chain_sel});
        end
        @(negedge tck); #1;
        trst = 1'b1;
        clk(1, 0); clk(0, 0);
    endtask

    task automatic test_idcode;
        logic [63:0] d;
        int oe_bad = 0;
        clk(1, 0); clk(0, 0); clk(0, 0);
        d = '0;
        for (int i = 0; i < 32; i++) begin
            d[i] = tdo;
            if (tdo_oe !== 1'b1) oe_bad++;
            clk(i == 31, 0);
        end
        total++;
        if (d[31:0] !== IDCODE) begin
            bad++; $display("FAIL idcode_scan got=%h exp=%h", d[31:0], IDCODE);
        end
        total++;
        if (oe_bad != 0) begin
            bad++; $display("FAIL idcode_oe_during_shift got=%0d_low_cycles exp=0", oe_bad);
        end
        total++;
        if (tdo_oe !== 1'b0) begin
            bad++; $display("FAIL idcode_oe_after_shift got=%b exp=0", tdo_oe);
        end
        clk(1, 0); clk(0, 0);
    endtask

    task automatic test_ir_bypass;
        logic [3:0]  cap;
        logic [63:0] d;
        load_ir(4'hF, cap);
        total++;
        if (cap !== 4'b0001) begin
            bad++; $display("FAIL ir_capture got=%b exp=0001", cap);
        end
        total++;
        if ({extest_sel, sample_sel, chain_sel} !== 5'b0) begin
            bad++; $display("FAIL bypass_selects got=%b exp=00000", {extest_sel, sample_sel, chain_sel});
        end
        clk(1, 0); clk(0, 0); clk(0, 0);
        shift_bits(4, 64'b1101, d);
        clk(1, 0); clk(0, 0);
        total++;
        if (d[3:0] !== 4'b1010) begin
            bad++; $display("FAIL bypass_delay got=%b exp=1010", d[3:0]);
        end
    endtask

    task automatic test_chain_strobes;
        logic [3:0] cap;
        logic [3:0] exp_s [6];
        logic [5:0] tms_seq;
        load_ir(4'd9, cap);
        total++;
        if (chain_sel !== 3'b010) begin
            bad++; $display("FAIL chain_select got=%b exp=010", chain_sel);
        end
        chain_tdi = 3'b010;
        clk(1, 0); clk(0, 0);
        total++;
        if ({shift_dr, pause_dr, update_dr, capture_dr} !== 4'b0001) begin
            bad++; $display("FAIL capture_strobe got=%b exp=0001", {shift_dr, pause_dr, update_dr, capture_dr});
        end
        clk(0, 0);
        total++;
        if ({shift_dr, tdo, tdo_oe} !== 3'b111) begin
            bad++; $display("FAIL chain_tdo got=%b exp=111", {shift_dr, tdo, tdo_oe});
        end
        // Exit1, Pause, Exit2, Shift, Exit1, Update
        tms_seq = 6'b110101;
        exp_s[0] = 4'b0000; exp_s[1] = 4'b0100; exp_s[2] = 4'b0000;
        exp_s[3] = 4'b1000; exp_s[4] = 4'b0000; exp_s[5] = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            clk(tms_seq[i], 0);
            total++;
            if ({shift_dr, pause_dr, update_dr, capture_dr} !== exp_s[i]) begin
                bad++; $display("FAIL strobe_step%0d got=%b exp=%b", i,
                    {shift_dr, pause_dr, update_dr, capture_dr}, exp_s[i]);
            end
        end
        clk(0, 0);
        chain_tdi = '0;
    endtask

    task automatic test_five_tms;
        logic [31:0] v;
        clk(1, 0); clk(0, 0); clk(0, 0);
        for (int i = 0; i < 5; i++) clk(1, 0);
        total++;
        if ({chain_sel, extest_sel, sample_sel, shift_dr, pause_dr, update_dr, capture_dr, tdo_oe} !== 10'b0) begin
            bad++; $display("FAIL tlr_outputs got=%b exp=0",
                {chain_sel, extest_sel, sample_sel, shift_dr, pause_dr, update_dr, capture_dr, tdo_oe});
        end
        clk(0, 0);
        read_idcode(v);
        total++;
        if (v !== IDCODE) begin
            bad++; $display("FAIL tlr_ir_idcode got=%h exp=%h", v, IDCODE);
        end
    endtask

    task automatic test_trst_mid_shift;
        logic [3:0]  cap;
        logic [31:0] v;
        load_ir(4'd9, cap);
        clk(1, 0); clk(1, 0); clk(0, 0); clk(0, 0);
        clk(0, 0); clk(0, 0);
        trst = 1'b0;
        #1;
        total++;
        if ({tdo_oe, tdo, chain_sel, extest_sel} !== 6'b0) begin
            bad++; $display("FAIL trst_immediate got=%b exp=000000", {tdo_oe, tdo, chain_sel, extest_sel});
        end
        @(negedge tck); #1;
        trst = 1'b1;
        clk(1, 0); clk(1, 0); clk(0, 0);
        total++;
        if ({extest_sel, chain_sel} !== 4'b0) begin
            bad++; $display("FAIL trst_no_update got=%b exp=0000", {extest_sel, chain_sel});
        end
        read_idcode(v);
        total++;
        if (v !== IDCODE) begin
            bad++; $display("FAIL trst_ir_idcode got=%h exp=%h", v, IDCODE);
        end
    endtask

    task automatic test_random_opcodes;
        logic [3:0]  op, cap;
        logic [63:0] din, dout, src, exp;
        logic [2:0]  exp_cs;
        int          kind;
        for (int it = 0; it < 24; it++) begin
            op = 4'($urandom_range(0, 15));
            kind = (op == 4'd2) ? 0 : (op <= 4'd1) ? 2 : (op >= 4'd8 && op <= 4'd10) ? 3 : 1;
            exp_cs = (kind == 3) ? 3'(1 << (op - 4'd8)) : 3'b000;
            load_ir(op, cap);
            total++;
            if ({cap, extest_sel, sample_sel, chain_sel} !== {4'b0001, op == 4'd0, op == 4'd1, exp_cs}) begin
                bad++; $display("FAIL rand_decode op=%0d got=%b exp=%b", op,
                    {cap, extest_sel, sample_sel, chain_sel}, {4'b0001, op == 4'd0, op == 4'd1, exp_cs});
            end
            din = {$urandom, $urandom};
            src = '0;
            dout = '0;
            clk(1, 0); clk(0, 0);
            bs_tdi = 1'($urandom); chain_tdi = 3'($urandom);
            src[0] = (kind == 2) ? bs_tdi : (kind == 3) ? chain_tdi[op - 4'd8] : 1'b0;
            clk(0, 0);
            for (int k = 0; k < 40; k++) begin
                dout[k] = tdo;
                bs_tdi = 1'($urandom); chain_tdi = 3'($urandom);
                src[k + 1] = (kind == 2) ? bs_tdi : (kind == 3) ? chain_tdi[op - 4'd8] : 1'b0;
                clk(k == 39, din[k]);
            end
            clk(1, 0); clk(0, 0);
            exp = '0;
            for (int k = 0; k < 40; k++) begin
                case (kind)
                    0:       exp[k] = (k < 32) ? IDCODE[k] : din[k - 32];
                    1:       exp[k] = (k == 0) ? 1'b0 : din[k - 1];
                    default: exp[k] = src[k];
                endcase
            end
            total++;
            if (dout[39:0] !== exp[39:0]) begin
                bad++; $display("FAIL rand_scan op=%0d got=%h exp=%h", op, dout[39:0], exp[39:0]);
            end
        end
        bs_tdi = 1'b0; chain_tdi = '0;
    endtask

    function automatic int model_next(input int s, input logic t);
        case (s)
            0: return t ? 0 : 1;    1: return t ? 2 : 1;
            2: return t ? 9 : 3;    3: return t ? 5 : 4;
            4: return t ? 5 : 4;    5: return t ? 8 : 6;
            6: return t ? 7 : 6;    7: return t ? 8 : 4;
            8: return t ? 2 : 1;    9: return t ? 0 : 10;
            10: return t ? 12 : 11; 11: return t ? 12 : 11;
            12: return t ? 15 : 13; 13: return t ? 14 : 13;
            14: return t ? 15 : 11; default: return t ? 2 : 1;
        endcase
    endfunction

    task automatic test_random_walk;
        int         s = 1;
        logic       t;
        logic [4:0] exp;
        for (int i = 0; i < 300; i++) begin
            t = 1'($urandom);
            clk(t, 1'($urandom));
            s = model_next(s, t);
            exp = {s == 4, s == 6, s == 8, s == 3, s == 4 || s == 11};
            total++;
            if ({shift_dr, pause_dr, update_dr, capture_dr, tdo_oe} !== exp) begin
                bad++; $display("FAIL walk_step%0d state=%0d got=%b exp=%b", i, s,
                    {shift_dr, pause_dr, update_dr, capture_dr, tdo_oe}, exp);
            end
        end
        for (int i = 0; i < 5; i++) clk(1, 0);
        total++;
        if ({chain_sel, extest_sel, sample_sel, shift_dr, pause_dr, update_dr, capture_dr, tdo_oe} !== 10'b0) begin
            bad++; $display("FAIL walk_five_tms got=%b exp=0",
                {chain_sel, extest_sel, sample_sel, shift_dr, pause_dr, update_dr, capture_dr, tdo_oe});
        end
        clk(0, 0);
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_ir_bypass();
        test_chain_strobes();
        test_five_tms();
        test_trst_mid_shift();
        test_random_opcodes();
        test_random_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
